// File: rtl/imm_rotate_unit.sv
// imm_rotate_unit: immediate extension for the multicycle datapath.
// Data-processing immediates are rotated right by 2*rot, STEP bits per cycle.
// ExtImm and carry_out stay put after done until the next accepted start.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; outputs hold the previous result
// ROTATE | rotating ExtImm right by STEP per cycle, counter counts down
// DONE   | one-cycle done pulse; result and carry valid
module imm_rotate_unit #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 24,
   parameter int STEP   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [IMM_W-1:0]  Instr,
   input  logic [1:0]        ImmSrc,
   input  logic              carry_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] ExtImm,
   output logic              carry_out
);

   // Enough counter range for the largest step count, 30/STEP.
   localparam int CNT_W = $clog2(30 / STEP + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_load;
   logic [DATA_W-1:0] ext_load, rot_nxt;
   logic [4:0]        rot2;
   logic              accept;

   assign accept  = (state == IDLE) && start;
   assign rot_nxt = {ExtImm[STEP-1:0], ExtImm[DATA_W-1:STEP]};

   // Unrotated extension and step count loaded when a start is accepted.
   always_comb begin
      ext_load = '0;
      rot2     = {Instr[11:8], 1'b0};
      cnt_load = '0;
      case (ImmSrc)
         2'b00: begin
            ext_load = {{(DATA_W-8){1'b0}}, Instr[7:0]};
            cnt_load = (STEP == 1) ? CNT_W'(rot2) : CNT_W'(rot2 >> 1);
         end
         2'b01:   ext_load = {{(DATA_W-12){1'b0}}, Instr[11:0]};
         2'b10:   ext_load = {{(DATA_W-IMM_W-2){Instr[IMM_W-1]}}, Instr, 2'b00};
         default: ext_load = {{(DATA_W-16){1'b0}}, Instr[15:0]};
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (cnt_load == '0) ? DONE : ROTATE;
         end
         ROTATE: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result register, step counter and carry; carry is written on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         ExtImm    <= '0;
         carry_out <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         ExtImm <= ext_load;
         cnt    <= cnt_load;
         if (cnt_load == '0) carry_out <= carry_in;
      end else if (state == ROTATE) begin
         ExtImm <= rot_nxt;
         cnt    <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) carry_out <= rot_nxt[DATA_W-1];
      end
   end

endmodule

// File: tb/tb_imm_rotate_unit.sv
// Bench for imm_rotate_unit: two instances (STEP=2 and STEP=1) share stimulus
// and are compared against an arithmetic reference model.
module tb_imm_rotate_unit;

   logic        clk = 1'b0;
   logic        reset, start, carry_in;
   logic [23:0] Instr;
   logic [1:0]  ImmSrc;
   logic        busy2, done2, co2, busy1, done1, co1;
   logic [31:0] ext2, ext1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   imm_rotate_unit #(.DATA_W(32), .IMM_W(24), .STEP(2)) u_s2 (
      .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ImmSrc(ImmSrc),
      .carry_in(carry_in), .busy(busy2), .done(done2), .ExtImm(ext2), .carry_out(co2));

   imm_rotate_unit #(.DATA_W(32), .IMM_W(24), .STEP(1)) u_s1 (
      .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ImmSrc(ImmSrc),
      .carry_in(carry_in), .busy(busy1), .done(done1), .ExtImm(ext1), .carry_out(co1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: extend, then rotate right by 2*rot via a doubled word.
   function automatic void model(input logic [23:0] ins, input logic [1:0] src, input logic cin,
                                 output logic [31:0] val, output logic c, output int amt);
      logic [63:0] dbl;
      amt = 0;
      case (src)
         2'b00: begin
            amt = 2 * int'(ins[11:8]);
            dbl = {32'(ins[7:0]), 32'(ins[7:0])} >> amt;
            val = dbl[31:0];
         end
         2'b01:   val = 32'(ins[11:0]);
         2'b10:   val = {{6{ins[23]}}, ins, 2'b00};
         default: val = 32'(ins[15:0]);
      endcase
      c = (amt != 0) ? val[31] : cin;
   endfunction

   // Issue one job in the current cycle T; check busy, done latency, result,
   // carry, the single-cycle done pulse and the held outputs afterwards.
   task automatic run_job(input logic [23:0] ins, input logic [1:0] src, input logic cin,
                          input bit disturb);
      logic [31:0] ev;
      logic        ec;
      int          amt, lat2, lat1;
      bit          d2, d1;
      model(ins, src, cin, ev, ec, amt);
      lat2 = 1 + amt / 2;
      lat1 = 1 + amt;
      start = 1'b1; Instr = ins; ImmSrc = src; carry_in = cin;
      d2 = 0; d1 = 0;
      for (int i = 1; i <= 40 && !(d2 && d1); i++) begin
         tick();
         start = 1'b0;
         Instr = 24'($urandom); ImmSrc = 2'($urandom); carry_in = 1'($urandom);
         if (disturb && (i == 2 || i == 3)) start = 1'b1;
         if (!d2) begin
            chk("busy_s2", 32'(busy2), 32'd1);
            if (done2) begin
               d2 = 1;
               chk("lat_s2", i, lat2);
               chk("ext_s2", ext2, ev);
               chk("carry_s2", 32'(co2), 32'(ec));
            end
         end
         if (!d1) begin
            chk("busy_s1", 32'(busy1), 32'd1);
            if (done1) begin
               d1 = 1;
               chk("lat_s1", i, lat1);
               chk("ext_s1", ext1, ev);
               chk("carry_s1", 32'(co1), 32'(ec));
            end
         end
      end
      if (!d2) chk("timeout_s2", 32'd0, 32'd1);
      if (!d1) chk("timeout_s1", 32'd0, 32'd1);
      start = 1'b0;
      tick();
      chk("post_s2", {busy2, done2, co2, ext2[28:0]}, {1'b0, 1'b0, ec, ev[28:0]});
      chk("post_s1", {busy1, done1, co1, ext1[28:0]}, {1'b0, 1'b0, ec, ev[28:0]});
      chk("post_hi_s2", 32'(ext2[31:29]), 32'(ev[31:29]));
      chk("post_hi_s1", 32'(ext1[31:29]), 32'(ev[31:29]));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; Instr = '0; ImmSrc = '0; carry_in = 1'b0;
      tick();
      tick();
      chk("rst_s2", {28'd0, busy2, done2, co2, |ext2}, 32'd0);
      chk("rst_s1", {28'd0, busy1, done1, co1, |ext1}, 32'd0);
      reset = 1'b0;
      tick();

      // Directed cases; each run_job returns in the cycle after done.
      run_job(24'h0004FF, 2'b00, 1'b0, 0);
      run_job(24'h00002A, 2'b00, 1'b1, 0);
      run_job(24'h000101, 2'b00, 1'b1, 0);
      run_job(24'hFFFFFE, 2'b10, 1'b0, 0);
      run_job(24'h000ABC, 2'b01, 1'b1, 0);
      run_job(24'h12ABCD, 2'b11, 1'b0, 0);
      run_job(24'h000F01, 2'b00, 1'b0, 0);
      run_job(24'h5A5481, 2'b00, 1'b1, 1);
      run_job(24'h7FFFFF, 2'b10, 1'b1, 0);
      run_job(24'h800000, 2'b10, 1'b0, 0);

      // Reset in cycle T+3 of a rotate=4 job abandons it with no done pulse.
      start = 1'b1; Instr = 24'h0004FF; ImmSrc = 2'b00; carry_in = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_s2", {28'd0, busy2, done2, co2, |ext2}, 32'd0);
      chk("midrst_s1", {28'd0, busy1, done1, co1, |ext1}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("nodone", {30'd0, done2, done1}, 32'd0);
      end
      run_job(24'h000381, 2'b00, 1'b0, 0);

      // Randomized jobs.
      for (int n = 0; n < 40; n++) begin
         run_job(24'($urandom), 2'($urandom), 1'($urandom), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imm_rotate_unit.md
# imm_rotate_unit

Sequential immediate-generation unit for the multicycle ARM datapath: decodes the instruction immediate field by ImmSrc and, for data-processing immediates, applies the architectural rotate-right by twice the 4-bit rotate field, iteratively at STEP bits per cycle. It also produces the shifter carry-out. It sits between the instruction register and the SrcB mux and is started by the control FSM during decode. Result and carry are held stable until the next accepted start.

## Interface
- DATA_W, default 32: width of the extended immediate; must be ≥ 32.
- IMM_W, default 24: width of the instruction immediate field (Instr[23:0]).
- STEP, default 2: rotate bits per ROTATE cycle; legal values are 1 and 2.
- Clocking/reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- Instr  in  IMM_W  instruction immediate field; captured on accept.
- ImmSrc  in  2  00 DP rotated imm8, 01 zero-ext imm12, 10 branch sign-ext <<2, 11 zero-ext Instr[15:0].
- carry_in  in  1  current C flag; captured on accept.
- busy  out  1  high from the accept edge until done is deasserted.
- done  out  1  one-cycle pulse; ExtImm/carry_out valid from this cycle on.
- ExtImm  out  DATA_W  extended/rotated immediate.
- carry_out  out  1  shifter carry-out.

## Operation
- FSM states: IDLE, ROTATE, DONE. Reset → IDLE.
- IDLE with start=1: the unit captures carry_in and loads the result register with the unrotated extension:
  - 00: zero-ext Instr[7:0].
  - 01: zero-ext Instr[11:0].
  - 10: sign-ext {Instr[23:0],2'b00} to DATA_W.
  - 11: zero-ext Instr[15:0].
- Step counter on accept:
  - ImmSrc=00: loads 2*Instr[11:8]/STEP.
  - All other ImmSrc: loads 0.
  - Counter width is sized for 30/STEP.
- Transition on accept: counter 0 → DONE; otherwise → ROTATE.
- ROTATE: each cycle the result rotates right by STEP, with bit wrap-around from LSB to MSB, and the counter decrements. The cycle that decrements from 1 → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- carry_out:
  - ImmSrc=00 with nonzero rotate: final ExtImm[DATA_W-1].
  - Otherwise: captured carry_in.
  - Written at the same edge that enters DONE.
- start in ROTATE or DONE is ignored; it is not queued.
- start in IDLE is accepted every time, including the cycle right after DONE.
- ExtImm and carry_out hold their last values in IDLE until the next accept.
- The rotate amount is always 2*rot with rot ≤ 15, so it is < DATA_W; no modulo handling is needed.

## Timing
- Reset values: busy=0, done=0, ExtImm=0, carry_out=0, counter=0, state IDLE.
- Reset takes priority over everything, including mid-ROTATE; the operation is abandoned with no done pulse.
- Latency, start accepted in cycle T:
  - done in cycle T+1 when the step count is 0.
  - done in cycle T+1+(2*rot/STEP) otherwise.
  - Maximum: T+16 with STEP=2, T+31 with STEP=1.
- busy is high in cycles T+1 through the done cycle inclusive; busy and done fall together.
- Instr, ImmSrc and carry_in are don't-care after the accept edge.
- ExtImm is not valid in intermediate ROTATE cycles; consumers sample only on or after done.

## Test plan
- ImmSrc=00, Instr[11:0]=0x4FF, STEP=2, carry_in=0 → ExtImm=0xFF000000, carry_out=1, done 5 cycles after start.
- ImmSrc=00, Instr[11:0]=0x02A, carry_in=1 → ExtImm=0x0000002A, carry_out=1, done 1 cycle after start. Repeat with Instr[11:0]=0x101 → ExtImm=0x40000000, carry_out=0, done at T+2.
- ImmSrc=10, Instr=0xFFFFFE → ExtImm=0xFFFFFFF8, done at T+1. ImmSrc=01, Instr=0x000ABC → 0x00000ABC. ImmSrc=11, Instr=0x12ABCD → 0x0000ABCD.
- ImmSrc=00, Instr[11:0]=0xF01, STEP=1 → ExtImm=0x00000004, done at T+31. STEP=2 → same value, done at T+16.
- Pulse start again with different Instr in cycles T+2 and T+3 of a rotate=4 job → ignored; original result returned. A start in the cycle after done is accepted.
- reset at T+3 of a rotate=4 job → cycle after: busy=0, ExtImm=0, carry_out=0, no done pulse. A new start then completes normally.
